// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
// State encoding and index wrap used by rr_packet_arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB = 2'b00,
    PKT = 2'b01
  } arb_state_e;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer with fully registered outputs.
// i_ready comes from a flop, so o_ready never reaches upstream combinationally.
module skid_buffer #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [WORD_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [WORD_WIDTH-1:0] o_data
);

  logic                  out_vld_q, out_vld_d;
  logic [WORD_WIDTH-1:0] out_dat_q, out_dat_d;
  logic                  sk_vld_q, sk_vld_d;
  logic [WORD_WIDTH-1:0] sk_dat_q, sk_dat_d;
  logic                  rdy_q;
  logic                  accept;
  logic                  drain;

  // Next-state: refill output from skid first, else from input
  always_comb begin
    accept    = i_valid & rdy_q;
    drain     = ~out_vld_q | o_ready;
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    sk_vld_d  = sk_vld_q;
    sk_dat_d  = sk_dat_q;
    if (drain) begin
      if (sk_vld_q) begin
        out_vld_d = 1'b1;
        out_dat_d = sk_dat_q;
        sk_vld_d  = 1'b0;
      end else if (accept) begin
        out_vld_d = 1'b1;
        out_dat_d = i_data;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      sk_vld_d = 1'b1;
      sk_dat_d = i_data;
    end
  end

  // Registers; ready is held low through reset
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      sk_vld_q  <= 1'b0;
      sk_dat_q  <= '0;
      rdy_q     <= 1'b0;
    end else begin
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      sk_vld_q  <= sk_vld_d;
      sk_dat_q  <= sk_dat_d;
      rdy_q     <= ~sk_vld_d;
    end
  end

  assign i_ready = rdy_q;
  assign o_valid = out_vld_q;
  assign o_data  = out_dat_q;

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter: grant locks to one input until its last beat.
// Arbitrated beats pass through a skid buffer so outputs are registered.
module rr_packet_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int WORD_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  input  logic [NUM_INPUTS*WORD_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_last,
  output logic                             o_valid,
  input  logic                             o_ready,
  output logic [WORD_WIDTH-1:0]            o_data,
  output logic                             o_last,
  output logic [$clog2(NUM_INPUTS)-1:0]    o_src
);

  import arb_pkg::*;

  localparam int SRC_BITS = $clog2(NUM_INPUTS);
  localparam int SB_W     = WORD_WIDTH + 1 + SRC_BITS;

  arb_state_e            state_q;
  logic [SRC_BITS-1:0]   rr_ptr_q;
  logic [SRC_BITS-1:0]   owner_q;
  logic [SRC_BITS-1:0]   cand;
  logic [SRC_BITS-1:0]   pick;
  logic                  pick_vld;
  logic [SRC_BITS-1:0]   gnt_idx;
  logic                  gnt_vld;
  logic [WORD_WIDTH-1:0] beat [NUM_INPUTS];
  logic                  sb_i_valid;
  logic                  sb_i_ready;
  logic [SB_W-1:0]       sb_i_data;
  logic [SB_W-1:0]       sb_o_data;
  logic                  xfer;
  logic                  xfer_last;

  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_beat
    assign beat[k] = in_data[k*WORD_WIDTH +: WORD_WIDTH];
  end

  // First valid requester scanning upward from rr_ptr with wrap
  always_comb begin
    cand     = rr_ptr_q;
    pick     = rr_ptr_q;
    pick_vld = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cand = SRC_BITS'((int'(rr_ptr_q) + i) % NUM_INPUTS);
      if (!pick_vld && in_valid[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Grant steering: owner while locked, round-robin pick otherwise
  always_comb begin
    gnt_idx = pick;
    gnt_vld = pick_vld;
    case (state_q)
      ARB: begin
        gnt_idx = pick;
        gnt_vld = pick_vld;
      end
      PKT: begin
        gnt_idx = owner_q;
        gnt_vld = 1'b1;
      end
      default: gnt_vld = 1'b0;
    endcase
    in_ready = '0;
    if (gnt_vld) in_ready[gnt_idx] = sb_i_ready;
    sb_i_valid = gnt_vld & in_valid[gnt_idx];
    xfer       = sb_i_valid & sb_i_ready;
    xfer_last  = in_last[gnt_idx];
    sb_i_data  = {in_last[gnt_idx], gnt_idx, beat[gnt_idx]};
  end

  // Packet lock FSM and round-robin pointer update
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ARB;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      case (state_q)
        ARB: begin
          if (xfer) begin
            if (xfer_last) begin
              rr_ptr_q <= SRC_BITS'(rr_next(int'(gnt_idx), NUM_INPUTS));
            end else begin
              owner_q <= gnt_idx;
              state_q <= PKT;
            end
          end
        end
        PKT: begin
          if (xfer && xfer_last) begin
            rr_ptr_q <= SRC_BITS'(rr_next(int'(owner_q), NUM_INPUTS));
            state_q  <= ARB;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  skid_buffer #(
    .WORD_WIDTH(SB_W)
  ) u_skid (
    .clk    (clk),
    .rst    (~reset_n),
    .i_valid(sb_i_valid),
    .i_ready(sb_i_ready),
    .i_data (sb_i_data),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .o_data (sb_o_data)
  );

  assign {o_last, o_src, o_data} = sb_o_data;

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Bench for rr_packet_arbiter: directed scenarios plus random packets
// scored against a packet-level round-robin model.
module tb_rr_packet_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic [31:0] in_data = '0;
  logic [3:0]  in_last = '0;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic [7:0]  o_data;
  logic        o_last;
  logic [1:0]  o_src;

  logic [2:0]  v3 = '0;
  logic [2:0]  r3;
  logic [23:0] d3 = '0;
  logic [2:0]  l3 = '0;
  logic        ov3;
  logic        or3 = 1'b0;
  logic [7:0]  od3;
  logic        ol3;
  logic [1:0]  os3;

  always #5 clk = ~clk;

  rr_packet_arbiter #(.NUM_INPUTS(4), .WORD_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_data(o_data), .o_last(o_last), .o_src(o_src)
  );

  rr_packet_arbiter #(.NUM_INPUTS(3), .WORD_WIDTH(8)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(v3), .in_ready(r3),
    .in_data(d3), .in_last(l3),
    .o_valid(ov3), .o_ready(or3),
    .o_data(od3), .o_last(ol3), .o_src(os3)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  mdat [4][16];
  logic        mlast [4][16];
  int          cnt [4];
  int          ptr [4];
  bit          acc [4];
  logic [10:0] obs_q [$];
  int          obs_cyc [$];
  logic [10:0] exp_q [$];
  int          cyc = 0;
  int          first_acc = -1;
  bit          ordy_rand = 0;
  logic        ordy_val = 1'b1;
  bit          stall_now = 0;
  bit          was_stall = 0;
  logic [10:0] word_now = '0;
  logic [10:0] was_word = '0;

  task automatic clear_bench();
    for (int k = 0; k < 4; k++) begin
      cnt[k] = 0;
      ptr[k] = 0;
      acc[k] = 0;
    end
    obs_q.delete();
    obs_cyc.delete();
    first_acc = -1;
    stall_now = 0;
    was_stall = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    in_valid = '0; in_last = '0; in_data = '0; o_ready = 1'b0;
    v3 = '0; l3 = '0; d3 = '0; or3 = 1'b0;
    clear_bench();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic add_pkt(input int k, input int len, input logic [7:0] base);
    for (int j = 0; j < len; j++) begin
      mdat[k][cnt[k]]  = base + 8'(j);
      mlast[k][cnt[k]] = (j == len - 1);
      cnt[k]++;
    end
  endtask

  // One cycle: apply inputs at negedge, sample what the next posedge will do
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (acc[k]) ptr[k]++;
      if (ptr[k] < cnt[k]) begin
        in_valid[k] = 1'b1;
        in_data[k*8 +: 8] = mdat[k][ptr[k]];
        in_last[k] = mlast[k][ptr[k]];
      end else begin
        in_valid[k] = 1'b0;
        in_data[k*8 +: 8] = 8'h00;
        in_last[k] = 1'b0;
      end
    end
    o_ready = ordy_rand ? 1'($urandom_range(0, 1)) : ordy_val;
    #1;
    for (int k = 0; k < 4; k++) begin
      acc[k] = in_valid[k] & in_ready[k];
      if (acc[k] && first_acc < 0) first_acc = cyc;
    end
    was_stall = stall_now;
    was_word  = word_now;
    stall_now = o_valid & ~o_ready;
    word_now  = {o_src, o_last, o_data};
    if (o_valid && o_ready) begin
      obs_q.push_back({o_src, o_last, o_data});
      obs_cyc.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic run_until(input int n, input int budget, output bit to);
    to = 0;
    while (obs_q.size() < n) begin
      if (budget == 0) begin
        to = 1;
        break;
      end
      budget--;
      step();
    end
  endtask

  // Packet-level model: whole packets in rotation order over non-empty inputs
  task automatic build_expected(input int rr0);
    int pos [4];
    int rr;
    int k;
    bit found;
    exp_q.delete();
    rr = rr0;
    for (int i = 0; i < 4; i++) pos[i] = 0;
    do begin
      found = 0;
      for (int i = 0; i < 4; i++) begin
        k = (rr + i) % 4;
        if (!found && pos[k] < cnt[k]) begin
          found = 1;
          forever begin
            exp_q.push_back({2'(k), mlast[k][pos[k]], mdat[k][pos[k]]});
            pos[k]++;
            if (mlast[k][pos[k]-1]) break;
          end
          rr = (k + 1) % 4;
        end
      end
    end while (found);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    in_valid = '1;
    in_last = '1;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 4'b0000 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL in_reset: in_ready=%b o_valid=%b want 0000/0", in_ready, o_valid);
    end
    in_valid = '0;
    in_last = '0;
    reset_n = 1'b1;
    ordy_rand = 0;
    ordy_val = 1'b1;
    repeat (5) begin
      step();
      checks++;
      if (o_valid !== 1'b0 || in_ready !== 4'b0000 || o_src !== 2'd0 ||
          o_data !== 8'h00 || o_last !== 1'b0) begin
        errors++;
        $display("FAIL idle: vld=%b rdy=%b src=%0d data=%h last=%b want 0/0000/0/00/0",
                 o_valid, in_ready, o_src, o_data, o_last);
      end
    end
  endtask

  task automatic test_single_beat();
    bit to;
    do_reset();
    ordy_rand = 0;
    ordy_val = 1'b1;
    for (int k = 0; k < 4; k++) add_pkt(k, 1, 8'h10 + 8'(k));
    run_until(4, 40, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL single_timeout: got %0d beats want 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_q[i] !== {2'(i), 1'b1, 8'h10 + 8'(i)}) begin
          errors++;
          $display("FAIL single_beat%0d: got %h want %h", i, obs_q[i],
                   {2'(i), 1'b1, 8'h10 + 8'(i)});
        end
        checks++;
        if (obs_cyc[i] !== obs_cyc[0] + i) begin
          errors++;
          $display("FAIL single_rate%0d: cycle %0d want %0d", i, obs_cyc[i], obs_cyc[0] + i);
        end
      end
      checks++;
      if (obs_cyc[0] !== first_acc + 1) begin
        errors++;
        $display("FAIL latency: first out cycle %0d want %0d", obs_cyc[0], first_acc + 1);
      end
    end
  endtask

  task automatic test_no_interleave();
    bit to;
    bit a3_done;
    int budget;
    do_reset();
    ordy_rand = 0;
    ordy_val = 1'b1;
    add_pkt(1, 3, 8'hA1);
    add_pkt(2, 1, 8'hB0);
    build_expected(0);
    a3_done = 0;
    budget = 40;
    to = 0;
    while (obs_q.size() < 4) begin
      if (budget == 0) begin
        to = 1;
        break;
      end
      budget--;
      step();
      if (!a3_done) begin
        checks++;
        if (in_ready[2] !== 1'b0) begin
          errors++;
          $display("FAIL lock_ready2: got %b want 0 before A3 accepted", in_ready[2]);
        end
        if (acc[1] && ptr[1] == 2) a3_done = 1;
      end
    end
    checks++;
    if (to) begin
      errors++;
      $display("FAIL interleave_timeout: got %0d beats want 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL interleave_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    bit to;
    int extra;
    logic [10:0] ref_w;
    do_reset();
    ordy_rand = 0;
    ordy_val = 1'b1;
    add_pkt(0, 4, 8'h50);
    add_pkt(3, 2, 8'h60);
    build_expected(0);
    repeat (2) step();
    ordy_val = 1'b0;
    extra = 0;
    ref_w = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      for (int k = 0; k < 4; k++) extra += int'(acc[k]);
      if (i == 0) ref_w = {o_src, o_last, o_data};
      checks++;
      if (o_valid !== 1'b1 || {o_src, o_last, o_data} !== ref_w) begin
        errors++;
        $display("FAIL stall_hold%0d: vld=%b word=%h want 1/%h", i, o_valid,
                 {o_src, o_last, o_data}, ref_w);
      end
    end
    checks++;
    if (extra > 1 || in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL stall_absorb: extra=%0d rdy=%b want <=1/0000", extra, in_ready);
    end
    ordy_val = 1'b1;
    run_until(6, 40, to);
    repeat (3) step();
    checks++;
    if (to || obs_q.size() != 6) begin
      errors++;
      $display("FAIL stall_count: got %0d beats want 6", obs_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL stall_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit to;
    int total;
    int budget;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      ordy_rand = 1;
      for (int k = 0; k < 4; k++) begin
        int npk;
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++)
          add_pkt(k, $urandom_range(1, 4), 8'($urandom_range(0, 255)));
      end
      build_expected(0);
      total = exp_q.size();
      budget = 600;
      to = 0;
      while (obs_q.size() < total) begin
        if (budget == 0) begin
          to = 1;
          break;
        end
        budget--;
        step();
        if (was_stall) begin
          checks++;
          if (o_valid !== 1'b1 || {o_src, o_last, o_data} !== was_word) begin
            errors++;
            $display("FAIL rnd_stall it%0d: vld=%b word=%h want 1/%h", it, o_valid,
                     {o_src, o_last, o_data}, was_word);
          end
        end
      end
      ordy_rand = 0;
      ordy_val = 1'b1;
      repeat (3) step();
      checks++;
      if (to || obs_q.size() != total) begin
        errors++;
        $display("FAIL rnd_count it%0d: got %0d beats want %0d", it, obs_q.size(), total);
      end else begin
        for (int i = 0; i < total; i++) begin
          checks++;
          if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rnd_beat it%0d #%0d: got %h want %h", it, i, obs_q[i], exp_q[i]);
          end
        end
      end
    end
  endtask

  task automatic test_rr_wrap3();
    logic [2:0] masks [3];
    logic [1:0] want [5];
    logic [2:0] pend;
    logic [2:0] a;
    logic [1:0] seen [$];
    logic [7:0] dseen [$];
    int budget;
    masks[0] = 3'b010; masks[1] = 3'b101; masks[2] = 3'b011;
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd0; want[3] = 2'd1; want[4] = 2'd0;
    do_reset();
    or3 = 1'b1;
    for (int p = 0; p < 3; p++) begin
      pend = masks[p];
      budget = 20;
      while (pend != 3'b000 && budget > 0) begin
        budget--;
        @(negedge clk);
        v3 = pend;
        l3 = 3'b111;
        d3 = {8'h22, 8'h21, 8'h20};
        #1;
        a = v3 & r3;
        if (ov3) begin
          seen.push_back(os3);
          dseen.push_back(od3);
        end
        pend = pend & ~a;
      end
    end
    repeat (3) begin
      @(negedge clk);
      v3 = '0;
      #1;
      if (ov3) begin
        seen.push_back(os3);
        dseen.push_back(od3);
      end
    end
    checks++;
    if (seen.size() != 5) begin
      errors++;
      $display("FAIL wrap3_count: got %0d beats want 5", seen.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (seen[i] !== want[i] || dseen[i] !== 8'h20 + 8'(want[i])) begin
          errors++;
          $display("FAIL wrap3_order%0d: got src %0d data %h want src %0d data %h",
                   i, seen[i], dseen[i], want[i], 8'h20 + 8'(want[i]));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int budget;
    bit hit;
    do_reset();
    ordy_rand = 0;
    ordy_val = 1'b1;
    add_pkt(2, 1, 8'h70);
    run_until(1, 20, to);
    add_pkt(0, 4, 8'h80);
    hit = 0;
    budget = 20;
    while (!hit && budget > 0) begin
      budget--;
      step();
      if (acc[0] && ptr[0] == 1) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL mid_setup: second beat never accepted");
    end
    @(negedge clk);
    reset_n = 1'b0;
    in_valid = '0;
    in_last = '0;
    @(negedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b0 || in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset: vld=%b rdy=%b want 0/0000", o_valid, in_ready);
    end
    do_reset();
    add_pkt(3, 2, 8'h90);
    add_pkt(1, 1, 8'h91);
    build_expected(0);
    run_until(3, 40, to);
    repeat (2) step();
    checks++;
    if (to || obs_q.size() != 3) begin
      errors++;
      $display("FAIL mid_after_count: got %0d beats want 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL mid_after_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_no_interleave();
    test_stall();
    test_rr_wrap3();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
